updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, step, limit and load widths in bits (WIDTH >= 2).
REQ-002 Parameter SATURATE, default 0: 0 = modulo wrap at boundaries, 1 = clamp at boundaries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-005 enable  input  1  1 = count by step this cycle; 0 = hold.
REQ-006 direction  input  1  1 = count up; 0 = count down.
REQ-007 load  input  1  1 = load load_value this cycle.
REQ-008 load_value  input  WIDTH  value for load.
REQ-009 step  input  WIDTH  increment/decrement magnitude, legal range 0..limit.
REQ-010 limit  input  WIDTH  maximum count; count range is 0..limit (modulus limit+1).
REQ-011 counter_out  output  WIDTH  registered count.
REQ-012 tc  output  1  registered terminal-count flag.
REQ-013 at_max  output  1  combinational, 1 when counter_out == limit.
REQ-014 at_min  output  1  combinational, 1 when counter_out == 0.

Function
REQ-015 Per-edge priority SHALL be: rst low > load > enable > hold.
REQ-016 Load SHALL set counter_out to load_value, or to limit if load_value > limit; tc <= 0.
REQ-017 enable=0 with load=0 SHALL hold counter_out and SHALL set tc <= 0.
REQ-018 Arithmetic SHALL use WIDTH+1-bit intermediates so no carry/borrow is lost.
REQ-019 Up, cnt+step <= limit: counter_out <= cnt+step, tc <= 0.
REQ-020 Up, cnt+step > limit, SATURATE=0: counter_out <= cnt+step-(limit+1), tc <= 1.
REQ-021 Up, cnt+step > limit, SATURATE=1: counter_out <= limit, tc <= 1.
REQ-022 Down, step <= cnt: counter_out <= cnt-step, tc <= 0.
REQ-023 Down, step > cnt, SATURATE=0: counter_out <= cnt+(limit+1)-step, tc <= 1.
REQ-024 Down, step > cnt, SATURATE=1: counter_out <= 0, tc <= 1.
REQ-025 Enabled step with counter_out > limit (limit lowered at runtime) SHALL set counter_out <= 0 and tc <= 1 regardless of direction.
REQ-026 step=0 with enable=1 SHALL hold counter_out, tc <= 0.
REQ-027 SATURATE=1 enabled steps against an already-clamped boundary SHALL keep counter_out at that boundary with tc <= 1 each cycle.
REQ-028 tc SHALL be valid in the same cycle as the counter_out value it qualifies (one-cycle latency from the causing edge).
REQ-029 step > limit is illegal; the block has no defined behaviour for it and benches SHALL NOT drive it.
REQ-030 limit=0 SHALL keep counter_out at 0; every enabled step with step=0 holds, no other step is legal.

Reset
REQ-031 rst=0 at a rising clk SHALL set counter_out=0, tc=0, overriding load and enable.
REQ-032 rst=0 between clock edges SHALL NOT change any output (synchronous reset).
REQ-033 Releasing rst SHALL allow normal operation from the first following rising edge.
REQ-034 Reset mid-count SHALL discard the in-progress step; no tc for that cycle.

Verification (WIDTH=8)
REQ-035 Reset: cnt=37, rst pulsed low mid-cycle with no edge -> cnt stays 37; rst low across an edge with load=1, load_value=5 -> cnt=0, tc=0.
REQ-036 Wrap up: SATURATE=0, limit=9, step=1, dir=1, start 8 -> 9 (tc=0, at_max=1), 0 (tc=1, at_min=1), 1 (tc=0).
REQ-037 Wrap down: SATURATE=0, limit=9, step=3, dir=0, start 1 -> 8 (tc=1), 5 (tc=0), 2, 9 (tc=1).
REQ-038 Saturate: SATURATE=1, limit=200, step=5, up from 198 -> 200 (tc=1), 200 (tc=1); down from 3 -> 0 (tc=1), 0 (tc=1).
REQ-039 Load: load=1, enable=1, load_value=50, limit=255 -> 50, tc=0; load_value=250, limit=9 -> 9.
REQ-040 Hold/limit change: enable=0 five cycles at 7 -> stays 7, tc=0; limit set to 5, enable=1 -> 0, tc=1.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: the master drives the count
// controls, and the slave returns the count and its flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             direction;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] counter_out;
    logic             tc;
    logic             at_max;
    logic             at_min;

    modport master (
        output enable, direction, load, load_value, step, limit,
        input  counter_out, tc, at_max, at_min
    );

    modport slave (
        input  enable, direction, load, load_value, step, limit,
        output counter_out, tc, at_max, at_min
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over the range 0..limit with a runtime step.
// It either wraps modulo limit+1 or clamps at the boundaries (SATURATE).
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    updown_mod_counter_if.slave   bus
);
    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;

    // One extra bit keeps the carry out of cnt+step and the value limit+1 exact.
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_lim_x;
    logic [WIDTH:0]   w_mod;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_up_wrap;
    logic [WIDTH:0]   w_dn_wrap;
    logic             w_up_ovf;
    logic             w_dn_unf;
    logic             w_oob;
    logic [WIDTH-1:0] w_nxt_cnt;
    logic             w_nxt_tc;

    assign w_cnt_x   = {1'b0, r_cnt};
    assign w_step_x  = {1'b0, bus.step};
    assign w_lim_x   = {1'b0, bus.limit};
    assign w_mod     = w_lim_x + ONE_X;
    assign w_sum     = w_cnt_x + w_step_x;
    assign w_up_wrap = w_sum - w_mod;
    assign w_dn_wrap = w_cnt_x + w_mod - w_step_x;
    assign w_up_ovf  = w_sum > w_lim_x;
    assign w_dn_unf  = w_step_x > w_cnt_x;
    assign w_oob     = r_cnt > bus.limit;

    always_comb begin
        w_nxt_cnt = r_cnt;
        w_nxt_tc  = 1'b0;
        if (bus.load) begin
            w_nxt_cnt = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
        end else if (bus.enable) begin
            if (w_oob) begin
                // The limit was lowered below the current count, so restart from zero.
                w_nxt_cnt = '0;
                w_nxt_tc  = 1'b1;
            end else if (bus.direction) begin
                if (w_up_ovf) begin
                    w_nxt_cnt = SATURATE ? bus.limit : w_up_wrap[WIDTH-1:0];
                    w_nxt_tc  = 1'b1;
                end else begin
                    w_nxt_cnt = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_unf) begin
                    w_nxt_cnt = SATURATE ? '0 : w_dn_wrap[WIDTH-1:0];
                    w_nxt_tc  = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - bus.step;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else begin
            r_cnt <= w_nxt_cnt;
            r_tc  <= w_nxt_tc;
        end
    end

    assign bus.counter_out = r_cnt;
    assign bus.tc          = r_tc;
    assign bus.at_max      = (r_cnt == bus.limit);
    assign bus.at_min      = (r_cnt == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrap instance and a saturate instance share
// the same stimulus, and an integer model is checked against both every cycle.
module tb_updown_mod_counter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    updown_mod_counter_if #(.WIDTH(W)) bus0 ();
    updown_mod_counter_if #(.WIDTH(W)) bus1 ();

    updown_mod_counter #(.WIDTH(W), .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    updown_mod_counter #(.WIDTH(W), .SATURATE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit t_en, t_dir, t_ld;
    int t_lv, t_st, t_lim;

    int m_cnt0, m_cnt1;
    bit m_tc0, m_tc1;
    bit m_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit e, input bit d, input bit l, input int v, input int s, input int li);
        t_en = e; t_dir = d; t_ld = l; t_lv = v; t_st = s; t_lim = li;
        bus0.enable = e; bus0.direction = d; bus0.load = l;
        bus0.load_value = W'(v); bus0.step = W'(s); bus0.limit = W'(li);
        bus1.enable = e; bus1.direction = d; bus1.load = l;
        bus1.load_value = W'(v); bus1.step = W'(s); bus1.limit = W'(li);
    endtask

    // Next-state rules, written directly in terms of integer arithmetic.
    task automatic mstep(input bit sat, inout int c, inout bit t);
        if (!rst) begin
            c = 0; t = 1'b0;
        end else if (t_ld) begin
            c = (t_lv > t_lim) ? t_lim : t_lv; t = 1'b0;
        end else if (!t_en) begin
            t = 1'b0;
        end else if (c > t_lim) begin
            c = 0; t = 1'b1;
        end else if (t_dir) begin
            if (c + t_st <= t_lim) begin c = c + t_st; t = 1'b0; end
            else begin c = sat ? t_lim : c + t_st - (t_lim + 1); t = 1'b1; end
        end else begin
            if (t_st <= c) begin c = c - t_st; t = 1'b0; end
            else begin c = sat ? 0 : c + t_lim + 1 - t_st; t = 1'b1; end
        end
    endtask

    task automatic cmp_model();
        chk("d0.cnt",    32'(bus0.counter_out), 32'(m_cnt0));
        chk("d0.tc",     32'(bus0.tc),          32'(m_tc0));
        chk("d0.at_max", 32'(bus0.at_max),      32'(m_cnt0 == t_lim));
        chk("d0.at_min", 32'(bus0.at_min),      32'(m_cnt0 == 0));
        chk("d1.cnt",    32'(bus1.counter_out), 32'(m_cnt1));
        chk("d1.tc",     32'(bus1.tc),          32'(m_tc1));
        chk("d1.at_max", 32'(bus1.at_max),      32'(m_cnt1 == t_lim));
        chk("d1.at_min", 32'(bus1.at_min),      32'(m_cnt1 == 0));
    endtask

    // Advance the model on the inputs now applied, cross one rising edge, then compare.
    task automatic tick();
        mstep(1'b0, m_cnt0, m_tc0);
        mstep(1'b1, m_cnt1, m_tc1);
        if (!rst) m_valid = 1'b1;
        @(posedge clk);
        #1;
        if (m_valid) cmp_model();
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 255);
        rst = 1'b0;
        tick(); tick();
        chk("reset.cnt", 32'(bus0.counter_out), 32'd0);
        chk("reset.tc",  32'(bus0.tc),          32'd0);
        rst = 1'b1;

        // A reset pulse with no edge inside it leaves the count alone.
        drv(0, 0, 1, 37, 0, 255); tick();
        chk("load37", 32'(bus0.counter_out), 32'd37);
        drv(0, 0, 0, 0, 0, 255);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        chk("rst_glitch", 32'(bus0.counter_out), 32'd37);
        tick();
        chk("rst_glitch_hold", 32'(bus0.counter_out), 32'd37);
        rst = 1'b0;
        drv(1, 1, 1, 5, 1, 255); tick();
        chk("rst_over_load.cnt", 32'(bus0.counter_out), 32'd0);
        chk("rst_over_load.tc",  32'(bus0.tc),          32'd0);
        rst = 1'b1;

        // Count up with wrap, limit 9.
        drv(0, 0, 1, 8, 0, 9); tick();
        drv(1, 1, 0, 0, 1, 9);
        tick(); chk("wup9", 32'(bus0.counter_out), 32'd9); chk("wup9.tc", 32'(bus0.tc), 32'd0);
        chk("wup9.at_max", 32'(bus0.at_max), 32'd1);
        tick(); chk("wup0", 32'(bus0.counter_out), 32'd0); chk("wup0.tc", 32'(bus0.tc), 32'd1);
        chk("wup0.at_min", 32'(bus0.at_min), 32'd1);
        tick(); chk("wup1", 32'(bus0.counter_out), 32'd1); chk("wup1.tc", 32'(bus0.tc), 32'd0);

        // Count down with wrap, step 3.
        drv(0, 0, 1, 1, 0, 9); tick();
        drv(1, 0, 0, 0, 3, 9);
        tick(); chk("wdn8", 32'(bus0.counter_out), 32'd8); chk("wdn8.tc", 32'(bus0.tc), 32'd1);
        tick(); chk("wdn5", 32'(bus0.counter_out), 32'd5); chk("wdn5.tc", 32'(bus0.tc), 32'd0);
        tick(); chk("wdn2", 32'(bus0.counter_out), 32'd2);
        tick(); chk("wdn9", 32'(bus0.counter_out), 32'd9); chk("wdn9.tc", 32'(bus0.tc), 32'd1);

        // Clamp at 200 on dut1; dut0 wraps 198+5 -> 2.
        drv(0, 0, 1, 198, 0, 200); tick();
        drv(1, 1, 0, 0, 5, 200);
        tick(); chk("sat_up", 32'(bus1.counter_out), 32'd200); chk("sat_up.tc", 32'(bus1.tc), 32'd1);
        chk("wrap_up203", 32'(bus0.counter_out), 32'd2);
        tick(); chk("sat_up2", 32'(bus1.counter_out), 32'd200); chk("sat_up2.tc", 32'(bus1.tc), 32'd1);
        drv(1, 1, 0, 0, 0, 200);
        tick(); chk("sat_step0", 32'(bus1.counter_out), 32'd200); chk("sat_step0.tc", 32'(bus1.tc), 32'd0);
        drv(0, 0, 1, 3, 0, 200); tick();
        drv(1, 0, 0, 0, 5, 200);
        tick(); chk("sat_dn", 32'(bus1.counter_out), 32'd0); chk("sat_dn.tc", 32'(bus1.tc), 32'd1);
        chk("wrap_dn199", 32'(bus0.counter_out), 32'd199);
        tick(); chk("sat_dn2", 32'(bus1.counter_out), 32'd0); chk("sat_dn2.tc", 32'(bus1.tc), 32'd1);

        // Load has priority over enable and is clamped to the limit.
        drv(1, 1, 1, 50, 0, 255); tick();
        chk("load50", 32'(bus0.counter_out), 32'd50); chk("load50.tc", 32'(bus0.tc), 32'd0);
        drv(1, 1, 1, 250, 0, 9); tick();
        chk("load_clamp", 32'(bus0.counter_out), 32'd9);

        // Hold for five cycles, then lower the limit below the count.
        drv(0, 0, 1, 7, 0, 255); tick();
        drv(0, 1, 0, 0, 1, 255);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold7", 32'(bus0.counter_out), 32'd7); chk("hold7.tc", 32'(bus0.tc), 32'd0);
        end
        drv(1, 1, 0, 0, 1, 5); tick();
        chk("oob.cnt", 32'(bus0.counter_out), 32'd0); chk("oob.tc", 32'(bus0.tc), 32'd1);

        // Reset during counting drops the step and gives no tc.
        drv(0, 0, 1, 4, 0, 9); tick();
        drv(1, 1, 0, 0, 1, 9); tick();
        chk("cnt5", 32'(bus0.counter_out), 32'd5);
        rst = 1'b0; tick();
        chk("rst_mid.cnt", 32'(bus0.counter_out), 32'd0); chk("rst_mid.tc", 32'(bus0.tc), 32'd0);
        rst = 1'b1;

        // Mixed sweep, with step kept within the limit; checked only against the model.
        for (int i = 0; i < 40; i++) begin
            drv((i % 5) != 0, ((i >> 0) & 1) != ((i >> 2) & 1), (i % 11) == 0,
                (i * 23) % 256, i % 7, 12 + (i % 4));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
